// File: rtl/td4_prog_loader.sv
// Program store for the TD4 core: a host loads bytes over slow async pins while the CPU is
// held in reset, and the CPU fetches from the same store combinationally.
module td4_prog_loader #(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] load_addr,
  output logic              load_done,
  output logic              overrun,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {RUN, LOAD, FULL} state_t;

  state_t                   state_reg, state_next;
  logic [SYNC_STAGES-1:0]   load_en_sync_reg;
  logic [SYNC_STAGES-1:0]   wr_sync_reg;
  logic                     wr_hist_reg;
  logic [ADDR_W-1:0]        load_addr_reg, load_addr_next;
  logic                     load_done_reg, load_done_next;
  logic                     overrun_reg, overrun_next;
  logic [DATA_W-1:0]        checksum_reg, checksum_next;
  logic                     cpu_hold_reg;
  logic                     mem_we;
  logic                     load_en_s;
  logic                     wr_pulse;
  logic [DATA_W-1:0]        mem [DEPTH];

  assign load_en_s = load_en_sync_reg[SYNC_STAGES-1];
  assign wr_pulse  = wr_sync_reg[SYNC_STAGES-1] & ~wr_hist_reg;

  // Both pins use equal-length chains so a strobe and load_en edge launched together arrive together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_en_sync_reg <= '0;
      wr_sync_reg      <= '0;
      wr_hist_reg      <= 1'b0;
    end else begin
      load_en_sync_reg <= {load_en_sync_reg[SYNC_STAGES-2:0], load_en};
      wr_sync_reg      <= {wr_sync_reg[SYNC_STAGES-2:0], wr_strobe};
      wr_hist_reg      <= wr_sync_reg[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      load_addr_reg <= '0;
      load_done_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      checksum_reg  <= '0;
      cpu_hold_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      load_addr_reg <= load_addr_next;
      load_done_reg <= load_done_next;
      overrun_reg   <= overrun_next;
      checksum_reg  <= checksum_next;
      // Registered from the next state so hold tracks the state exactly with no decode glitches.
      cpu_hold_reg  <= (state_next != RUN);
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_addr_next = load_addr_reg;
    load_done_next = load_done_reg;
    overrun_next   = overrun_reg;
    checksum_next  = checksum_reg;
    mem_we         = 1'b0;
    case (state_reg)
      RUN: begin
        if (load_en_s) begin
          state_next     = LOAD;
          load_addr_next = '0;
          load_done_next = 1'b0;
          overrun_next   = 1'b0;
          checksum_next  = '0;
        end
      end
      LOAD: begin
        if (wr_pulse) begin
          mem_we        = 1'b1;
          checksum_next = checksum_reg + wr_data;
          if (load_addr_reg == ADDR_W'(DEPTH - 1)) begin
            load_addr_next = '0;
            load_done_next = 1'b1;
            state_next     = FULL;
          end else begin
            load_addr_next = load_addr_reg + ADDR_W'(1);
          end
        end
        // A write coinciding with load_en falling still commits above.
        if (!load_en_s) state_next = RUN;
      end
      FULL: begin
        if (wr_pulse) overrun_next = 1'b1;
        if (!load_en_s) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem[gi] <= '0;
        else if (mem_we && (load_addr_reg == ADDR_W'(gi)))
          mem[gi] <= wr_data;
      end
    end
  endgenerate

  assign cpu_instr = mem[cpu_addr];
  assign cpu_hold  = cpu_hold_reg;
  assign load_addr = load_addr_reg;
  assign load_done = load_done_reg;
  assign overrun   = overrun_reg;
  assign checksum  = checksum_reg;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: load, overrun, partial load, strobe edge cases, async reset.
module tb_td4_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic       wr_strobe;
  logic [7:0] wr_data;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_instr;
  logic       cpu_hold;
  logic [3:0] load_addr;
  logic       load_done;
  logic       overrun;
  logic [7:0] checksum;

  int tests = 0;
  int fails = 0;

  td4_prog_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .wr_strobe (wr_strobe),
    .wr_data   (wr_data),
    .cpu_addr  (cpu_addr),
    .cpu_instr (cpu_instr),
    .cpu_hold  (cpu_hold),
    .load_addr (load_addr),
    .load_done (load_done),
    .overrun   (overrun),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int a, input logic [7:0] exp);
    cpu_addr = 4'(a);
    #1;
    chk($sformatf("%s[%0d]", tag, a), {24'd0, cpu_instr}, {24'd0, exp});
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    wr_data   = b;
    wr_strobe = 1'b1;
    clks(5);
    wr_strobe = 1'b0;
    clks(3);
  endtask

  task automatic enter_load();
    @(negedge clk);
    load_en = 1'b1;
    clks(4);
  endtask

  task automatic leave_load();
    @(negedge clk);
    load_en = 1'b0;
    clks(4);
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; wr_strobe = 1'b0; wr_data = 8'h00; cpu_addr = 4'd0;
    clks(3);
    rst_n = 1'b1;
    clks(2);

    // Reset state
    chk("rst_cpu_hold",  32'(cpu_hold),  32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_checksum",  32'(checksum),  32'd0);
    chk("rst_load_addr", 32'(load_addr), 32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    for (int k = 0; k < 16; k++) chk_word("rst_mem", k, 8'h00);

    // Full load 0x00..0x0F with exact write latency on the first byte
    enter_load();
    chk("load_cpu_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    wr_data = 8'h00; wr_strobe = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("lat_before_3rd_edge", 32'(load_addr), 32'd0);
    @(posedge clk); #1;
    chk("lat_at_3rd_edge", 32'(load_addr), 32'd1);
    clks(3);
    wr_strobe = 1'b0;
    clks(3);
    for (int k = 1; k < 15; k++) strobe(8'(k));
    chk("done_before_16th", 32'(load_done), 32'd0);
    strobe(8'h0F);
    chk("done_after_16th", 32'(load_done), 32'd1);
    chk("full_checksum",   32'(checksum),  32'h78);
    chk("full_load_addr",  32'(load_addr), 32'd0);
    chk("full_cpu_hold",   32'(cpu_hold),  32'd1);

    // Overrun
    strobe(8'hFF);
    chk("ovr_flag",     32'(overrun),  32'd1);
    chk("ovr_checksum", 32'(checksum), 32'h78);
    chk_word("ovr_mem0", 0, 8'h00);
    leave_load();
    chk("run_cpu_hold",  32'(cpu_hold),  32'd0);
    chk("run_load_done", 32'(load_done), 32'd1);
    chk("run_overrun",   32'(overrun),   32'd1);
    for (int k = 0; k < 16; k++) chk_word("full_mem", k, 8'(k));

    // Re-entry clears session status; partial load keeps other words
    enter_load();
    chk("reent_overrun",   32'(overrun),   32'd0);
    chk("reent_load_done", 32'(load_done), 32'd0);
    chk("reent_checksum",  32'(checksum),  32'd0);
    strobe(8'hB3);
    strobe(8'h01);
    leave_load();
    chk("part_load_done", 32'(load_done), 32'd0);
    chk("part_checksum",  32'(checksum),  32'hB4);
    chk("part_cpu_hold",  32'(cpu_hold),  32'd0);
    chk_word("part_mem", 0, 8'hB3);
    chk_word("part_mem", 1, 8'h01);
    chk_word("part_mem", 2, 8'h02);
    chk_word("part_mem", 15, 8'h0F);

    // Strobe held high 50 cycles -> one write
    enter_load();
    @(negedge clk);
    wr_data = 8'h5A; wr_strobe = 1'b1;
    clks(50);
    wr_strobe = 1'b0;
    clks(3);
    chk("held_load_addr", 32'(load_addr), 32'd1);
    chk("held_checksum",  32'(checksum),  32'h5A);
    leave_load();
    chk_word("held_mem", 0, 8'h5A);
    chk_word("held_mem", 1, 8'h01);

    // Strobe edge coincident with load_en falling -> write still commits
    enter_load();
    @(negedge clk);
    wr_data = 8'h3C; wr_strobe = 1'b1; load_en = 1'b0;
    clks(5);
    wr_strobe = 1'b0;
    clks(3);
    chk("coin_load_addr", 32'(load_addr), 32'd1);
    chk("coin_checksum",  32'(checksum),  32'h3C);
    chk("coin_cpu_hold",  32'(cpu_hold),  32'd0);
    chk_word("coin_mem", 0, 8'h3C);
    chk_word("coin_mem", 1, 8'h01);

    // Final (16th) write coincident with load_en falling
    enter_load();
    for (int k = 0; k < 15; k++) strobe(8'h11);
    @(negedge clk);
    wr_data = 8'h22; wr_strobe = 1'b1; load_en = 1'b0;
    clks(5);
    wr_strobe = 1'b0;
    clks(3);
    chk("last_load_done", 32'(load_done), 32'd1);
    chk("last_cpu_hold",  32'(cpu_hold),  32'd0);
    chk("last_checksum",  32'(checksum),  32'h21);
    chk("last_load_addr", 32'(load_addr), 32'd0);
    chk_word("last_mem", 14, 8'h11);
    chk_word("last_mem", 15, 8'h22);

    // Async reset mid-load after 5 writes
    enter_load();
    for (int k = 0; k < 5; k++) strobe(8'hA0 + 8'(k));
    chk("pre_rst_load_addr", 32'(load_addr), 32'd5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cpu_hold",  32'(cpu_hold),  32'd0);
    chk("arst_load_addr", 32'(load_addr), 32'd0);
    chk("arst_checksum",  32'(checksum),  32'd0);
    for (int k = 0; k < 16; k++) chk_word("arst_mem", k, 8'h00);
    load_en = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(4);
    chk("post_rst_cpu_hold", 32'(cpu_hold), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
